// File: rtl/grant_lock_mux.sv
// Packet-locking N:1 beat mux. An external arbiter picks a requestor in IDLE, and the mux
// then forwards that requestor's beats through a one-deep output register until s_last.
//
// state | meaning
// IDLE  | arb_req mirrors s_valid; waiting for a legal one-hot grant
// LOCK  | forwarding beats from sel until a beat with s_last is accepted
module grant_lock_mux #(
    parameter int DW     = 3,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DW-1:0]        s_valid,
    input  logic [DW*DATA_W-1:0] s_data,
    input  logic [DW-1:0]        s_last,
    output logic [DW-1:0]        s_ready,
    output logic [DW-1:0]        arb_req,
    input  logic [DW-1:0]        arb_grant,
    output logic                 m_valid,
    output logic [DATA_W-1:0]    m_data,
    output logic                 m_last,
    output logic [DW-1:0]        m_src,
    input  logic                 m_ready,
    output logic                 busy
);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t              state;
    logic [DW-1:0]       sel;
    logic [DATA_W-1:0]   sel_data;
    logic                sel_last;
    logic                accept;
    logic                grant_ok;

    // sel is one-hot, so an OR-reduction over masked slices is the selected payload
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < DW; i++) begin
            if (sel[i]) begin
                sel_data = sel_data | s_data[i*DATA_W +: DATA_W];
                sel_last = sel_last | s_last[i];
            end
        end
    end

    assign grant_ok = $onehot(arb_grant) && (|(arb_grant & s_valid));
    assign arb_req  = (state == IDLE) ? s_valid : '0;
    assign s_ready  = ((state == LOCK) && (!m_valid || m_ready)) ? sel : '0;
    assign accept   = |(s_valid & s_ready);
    assign busy     = (state == LOCK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sel     <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
            m_src   <= '0;
        end else begin
            if (accept) begin
                m_valid <= 1'b1;
                m_data  <= sel_data;
                m_last  <= sel_last;
                m_src   <= sel;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (grant_ok) begin
                        sel   <= arb_grant;
                        state <= LOCK;
                    end
                end
                LOCK: begin
                    if (accept && sel_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_grant_lock_mux.sv
// Directed bench for grant_lock_mux (DW=3, DATA_W=32) with hand-computed expectations.
module tb_grant_lock_mux;

    logic        clk;
    logic        rst;
    logic [2:0]  s_valid;
    logic [95:0] s_data;
    logic [2:0]  s_last;
    logic [2:0]  s_ready;
    logic [2:0]  arb_req;
    logic [2:0]  arb_grant;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_last;
    logic [2:0]  m_src;
    logic        m_ready;
    logic        busy;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    grant_lock_mux #(.DW(3), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .arb_req(arb_req), .arb_grant(arb_grant),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_src(m_src),
        .m_ready(m_ready), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int i, input logic [31:0] v);
        s_data[i*32 +: 32] = v;
    endtask

    initial begin
        rst = 1'b1; s_valid = '0; s_data = '0; s_last = '0; arb_grant = '0; m_ready = 1'b1;
        #2;
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_busy",    64'(busy),    64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_m_data",  64'(m_data),  64'd0);
        chk("rst_m_src",   64'(m_src),   64'd0);
        chk("rst_m_last",  64'(m_last),  64'd0);
        #1 rst = 1'b0;

        // 4-beat packet from requestor 1 with m_ready held high
        s_valid = 3'b010; arb_grant = 3'b010;
        #1;
        chk("t1_arb_req_idle", 64'(arb_req), 64'h2);
        chk("t1_s_ready_idle", 64'(s_ready), 64'h0);
        tick();
        arb_grant = 3'b000;
        for (int b = 1; b <= 4; b++) begin
            put(1, 32'h10 + 32'(b));
            s_last = (b == 4) ? 3'b010 : 3'b000;
            #1;
            chk("t1_busy",    64'(busy),    64'd1);
            chk("t1_s_ready", 64'(s_ready), 64'h2);
            chk("t1_arb_req", 64'(arb_req), 64'h0);
            tick();
            chk("t1_m_valid", 64'(m_valid), 64'd1);
            chk("t1_m_data",  64'(m_data),  64'h10 + 64'(b));
            chk("t1_m_src",   64'(m_src),   64'h2);
            chk("t1_m_last",  64'(m_last),  (b == 4) ? 64'd1 : 64'd0);
        end
        chk("t1_idle_after", 64'(busy), 64'd0);
        s_valid = 3'b000; s_last = 3'b000;
        tick();
        chk("t1_m_valid_drop", 64'(m_valid), 64'd0);

        // Lock on requestor 0 while all requestors are valid; later grants ignored
        s_valid = 3'b111; arb_grant = 3'b001;
        put(1, 32'h0000BAD1); put(2, 32'h0000BAD2);
        #1;
        chk("t2_arb_req_idle", 64'(arb_req), 64'h7);
        tick();
        arb_grant = 3'b110;
        for (int b = 0; b < 3; b++) begin
            put(0, 32'h20 + 32'(b));
            s_last = (b == 2) ? 3'b111 : 3'b110;
            #1;
            chk("t2_s_ready", 64'(s_ready), 64'h1);
            chk("t2_arb_req", 64'(arb_req), 64'h0);
            tick();
            chk("t2_m_data", 64'(m_data), 64'h20 + 64'(b));
            chk("t2_m_src",  64'(m_src),  64'h1);
        end
        chk("t2_idle_after", 64'(busy), 64'd0);
        arb_grant = 3'b000;

        // New grant while the last beat is still held, then backpressure on 0xA5A5A5A5
        s_valid = 3'b001; s_last = 3'b000; put(0, 32'hA5A5A5A5);
        arb_grant = 3'b001; m_ready = 1'b0;
        #1;
        chk("t3_arb_req_idle", 64'(arb_req), 64'h1);
        tick();
        arb_grant = 3'b000;
        chk("t3_busy",         64'(busy),    64'd1);
        chk("t3_hold_valid",   64'(m_valid), 64'd1);
        chk("t3_hold_data",    64'(m_data),  64'h22);
        chk("t3_blocked",      64'(s_ready), 64'h0);
        m_ready = 1'b1;
        #1;
        chk("t3_unblocked", 64'(s_ready), 64'h1);
        tick();
        chk("t3_a5_data", 64'(m_data), 64'hA5A5A5A5);
        m_ready = 1'b0; put(0, 32'h5A5A5A5A); s_last = 3'b001;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("t3_bp_s_ready", 64'(s_ready), 64'h0);
            tick();
            chk("t3_bp_valid", 64'(m_valid), 64'd1);
            chk("t3_bp_data",  64'(m_data),  64'hA5A5A5A5);
            chk("t3_bp_src",   64'(m_src),   64'h1);
            chk("t3_bp_last",  64'(m_last),  64'd0);
        end
        m_ready = 1'b1;
        #1;
        chk("t3_release_ready", 64'(s_ready), 64'h1);
        tick();
        chk("t3_next_data", 64'(m_data), 64'h5A5A5A5A);
        chk("t3_next_last", 64'(m_last), 64'd1);
        chk("t3_idle",      64'(busy),   64'd0);
        s_valid = 3'b000; s_last = 3'b000;
        tick();
        chk("t3_drained", 64'(m_valid), 64'd0);

        // Illegal grants: multi-hot, non-matching, zero
        s_valid = 3'b001; arb_grant = 3'b011;
        tick();
        chk("t4_multihot", 64'(busy), 64'd0);
        arb_grant = 3'b100;
        tick();
        chk("t4_nonmatch", 64'(busy), 64'd0);
        arb_grant = 3'b000;
        tick();
        chk("t4_zero",    64'(busy),    64'd0);
        chk("t4_s_ready", 64'(s_ready), 64'h0);

        // Async reset after beat 2 of a 5-beat packet from requestor 2
        s_valid = 3'b100; arb_grant = 3'b100;
        tick();
        arb_grant = 3'b000;
        chk("t5_busy", 64'(busy), 64'd1);
        for (int b = 1; b <= 2; b++) begin
            put(2, 32'h30 + 32'(b));
            tick();
            chk("t5_m_data", 64'(m_data), 64'h30 + 64'(b));
        end
        #1 rst = 1'b1;
        #1;
        chk("t5_rst_m_valid", 64'(m_valid), 64'd0);
        chk("t5_rst_busy",    64'(busy),    64'd0);
        chk("t5_rst_s_ready", 64'(s_ready), 64'h0);
        chk("t5_rst_m_data",  64'(m_data),  64'd0);
        #1 rst = 1'b0;
        s_valid = 3'b001; arb_grant = 3'b001; put(0, 32'h77); s_last = 3'b001;
        tick();
        arb_grant = 3'b000;
        chk("t5_relock_busy",    64'(busy),    64'd1);
        chk("t5_relock_s_ready", 64'(s_ready), 64'h1);
        tick();
        chk("t5_single_valid", 64'(m_valid), 64'd1);
        chk("t5_single_data",  64'(m_data),  64'h77);
        chk("t5_single_last",  64'(m_last),  64'd1);
        chk("t5_single_src",   64'(m_src),   64'h1);
        chk("t5_single_idle",  64'(busy),    64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/grant_lock_mux.md
GRANT_LOCK_MUX -- requirements
Module: grant_lock_mux

Interface
REQ-001 SHALL have parameter DW, default 3, number of requestors (DW >= 2).
REQ-002 SHALL have parameter DATA_W, default 32, payload width per requestor.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port s_valid  input  DW  per-requestor beat valid.
REQ-006 SHALL have port s_data  input  DW*DATA_W  payloads; requestor i occupies bits [i*DATA_W +: DATA_W].
REQ-007 SHALL have port s_last  input  DW  per-requestor end-of-packet marker.
REQ-008 SHALL have port s_ready  output  DW  per-requestor beat accept.
REQ-009 SHALL have port arb_req  output  DW  request vector to the round-robin arbiter.
REQ-010 SHALL have port arb_grant  input  DW  grant vector from the arbiter, same cycle as arb_req.
REQ-011 SHALL have port m_valid  output  1  registered output beat valid.
REQ-012 SHALL have port m_data  output  DATA_W  registered output payload.
REQ-013 SHALL have port m_last  output  1  registered end-of-packet marker.
REQ-014 SHALL have port m_src  output  DW  one-hot source of the current m_data beat.
REQ-015 SHALL have port m_ready  input  1  downstream accept.
REQ-016 SHALL have port busy  output  1  high while a packet is locked.

Function
REQ-017 SHALL implement a two-state FSM: IDLE, LOCK.
REQ-018 In IDLE, arb_req SHALL equal s_valid and s_ready SHALL be all zeros.
REQ-019 In IDLE, if arb_grant is exactly one-hot and arb_grant & s_valid is nonzero, the block SHALL register sel <= arb_grant and enter LOCK on the next edge.
REQ-020 In IDLE, a zero, multi-hot, or non-valid-matching arb_grant SHALL be ignored; the FSM stays in IDLE.
REQ-021 In LOCK, arb_req SHALL be all zeros and arb_grant SHALL be ignored.
REQ-022 In LOCK, s_ready SHALL equal sel when (!m_valid || m_ready), else zero; non-selected requestors never see s_ready high.
REQ-023 A beat SHALL be accepted when s_valid & s_ready is nonzero for the selected requestor; on that edge m_valid<=1, m_data/m_last<=selected s_data/s_last, m_src<=sel.
REQ-024 Latency SHALL be exactly one cycle from source acceptance to m_valid; sustained throughput SHALL be one beat per cycle while m_ready stays high.
REQ-025 When m_valid=1 and m_ready=0, m_valid, m_data, m_last and m_src SHALL hold stable.
REQ-026 When m_valid=1, m_ready=1 and no new beat is accepted, m_valid SHALL drop to 0 on the next edge.
REQ-027 Acceptance of a beat with s_last=1 SHALL return the FSM to IDLE on that edge; the output register still presents that final beat.
REQ-028 Single-beat packets (s_last=1 on first beat) SHALL take one LOCK cycle minimum.
REQ-029 busy SHALL equal (state == LOCK).
REQ-030 A new grant in IDLE SHALL be processed even while the previous packet's last beat is still held in the output register; its first beat waits for s_ready per REQ-022.

Reset
REQ-031 While rst=1, state=IDLE, sel=0, m_valid=0, m_data=0, m_last=0, m_src=0, busy=0, s_ready=0.
REQ-032 Reset asserted mid-packet SHALL discard the locked packet and any held output beat immediately; after release the block starts in IDLE.

Verification
REQ-033 DW=3: s_valid=3'b010, arb_grant=3'b010 in IDLE, 4-beat packet with last on beat 4, m_ready=1 -> busy for 4 cycles, m_src=3'b010 on 4 consecutive m_valid beats, m_last only on 4th, IDLE after.
REQ-034 Locked on requestor 0, s_valid=3'b111 throughout -> s_ready only ever 3'b001 or 3'b000; arb_req=0 while busy; no beats from requestors 1/2 until IDLE.
REQ-035 Backpressure: m_ready=0 for 3 cycles with m_valid=1, m_data=0xA5A5A5A5 -> output held constant, s_ready=0, no beat lost or duplicated once m_ready=1.
REQ-036 Illegal grants in IDLE: arb_grant=3'b011, then 3'b100 with s_valid=3'b001 -> FSM stays IDLE, busy=0.
REQ-037 rst asserted asynchronously after beat 2 of a 5-beat packet -> m_valid=0, busy=0, s_ready=0 without a clock edge; after release, new grant 3'b001 locks normally.
